// File: rtl/msx_mapper_bank.sv
// msx_mapper_bank: multi-channel MSX2 memory mapper with init sequencer, readback and address translation
// Ports: clk/reset_n clock and async active-low reset; io_sel/io_wr/io_rd/io_addr/io_din/io_dout
// are the FC-FF register port; chan_size/chan_base give per-channel segment count and physical base;
// tr_req/tr_ch/tr_addr -> tr_valid/tr_phys/tr_seg is the one-cycle translation pipeline; busy flags init.
module msx_mapper_bank #(
  parameter int CHANNELS  = 3,
  parameter int SEG_W     = 8,
  parameter int ADDR_W    = 24,
  parameter int INIT_MODE = 1,
  parameter int RB_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CHANNELS-1:0]          io_sel,
  input  logic                         io_wr,
  input  logic                         io_rd,
  input  logic [1:0]                   io_addr,
  input  logic [7:0]                   io_din,
  output logic [7:0]                   io_dout,
  input  logic [CHANNELS*8-1:0]        chan_size,
  input  logic [CHANNELS*ADDR_W-1:0]   chan_base,
  input  logic                         tr_req,
  input  logic [2:0]                   tr_ch,
  input  logic [15:0]                  tr_addr,
  output logic                         tr_valid,
  output logic [ADDR_W-1:0]            tr_phys,
  output logic [7:0]                   tr_seg,
  output logic                         busy
);
  typedef enum logic [1:0] {INIT, FILL, RUN} state_t;
  localparam logic [4:0] LAST = 5'(CHANNELS*4-1);
  state_t state_q, state_d;
  logic [4:0] cnt_q;
  logic [SEG_W-1:0] seg_q [CHANNELS][4];
  logic [7:0] mask [CHANNELS];
  logic [2:0] wr_ch;
  logic hit, wr_en, tr_ok;
  logic [SEG_W-1:0] rd_seg, tr_seg_c;
  logic [7:0] rd_mask, rb_pad;
  logic [ADDR_W-1:0] tr_base, tr_phys_c;
  // size 0 wraps to mask FF, which is how 256 segments is encoded
  always_comb
    for (int c = 0; c < CHANNELS; c++) mask[c] = chan_size[c*8 +: 8] - 8'd1;
  // descending scan so the lowest selected channel ends up winning
  always_comb begin
    wr_ch = '0;
    for (int c = CHANNELS-1; c >= 0; c--) if (io_sel[c]) wr_ch = 3'(c);
  end
  assign hit   = |io_sel;
  assign busy  = state_q != RUN;
  assign wr_en = io_wr & hit & ~busy;
  assign tr_ok = {1'b0, tr_ch} < 4'(CHANNELS);
  always_comb begin
    rd_seg   = '0;
    rd_mask  = '1;
    tr_seg_c = '0;
    tr_base  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_ch == 3'(c)) rd_mask = mask[c];
      if (tr_ch == 3'(c)) tr_base = chan_base[c*ADDR_W +: ADDR_W];
      for (int p = 0; p < 4; p++) begin
        if (wr_ch == 3'(c) && io_addr == 2'(p)) rd_seg = seg_q[c][p];
        if (tr_ch == 3'(c) && tr_addr[15:14] == 2'(p)) tr_seg_c = seg_q[c][p];
      end
    end
  end
  always_comb begin
    rb_pad = '1;
    rb_pad[SEG_W-1:0] = rd_seg;
  end
  assign io_dout   = (busy || !io_rd || !hit || RB_MODE != 0) ? 8'hFF : (rb_pad | ~rd_mask);
  assign tr_phys_c = tr_base + (ADDR_W'(tr_seg_c) << 14) + ADDR_W'(tr_addr[13:0]);
  always_comb
    state_d = state_q == INIT ? FILL : (state_q == FILL && cnt_q == LAST) ? RUN : state_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= state_q == FILL ? cnt_q + 5'd1 : '0;
    end
  // fill counter is {ch, page}, so slot c*4+p belongs to channel c, page p
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int p = 0; p < 4; p++) seg_q[c][p] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        for (int p = 0; p < 4; p++)
          if (state_q == FILL && cnt_q == 5'(c*4+p))
            seg_q[c][p] <= (INIT_MODE == 1 ? SEG_W'(3-p) : '0) & mask[c][SEG_W-1:0];
          else if (wr_en && wr_ch == 3'(c) && io_addr == 2'(p))
            seg_q[c][p] <= io_din[SEG_W-1:0] & mask[c][SEG_W-1:0];
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tr_valid <= 1'b0;
      tr_phys  <= '0;
      tr_seg   <= '0;
    end else begin
      tr_valid <= tr_req & ~busy;
      if (tr_req && !busy) begin
        tr_phys <= tr_ok ? tr_phys_c : '0;
        tr_seg  <= tr_ok ? 8'(tr_seg_c) : '0;
      end
    end
endmodule
